// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and dm memory signals of the load/store unit
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] rw_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_write, rw_addr, write_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_write, rw_addr, write_data
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - byte/halfword/word load/store unit over a word-only data memory
module lsu #(
  parameter int MEM_WORDS = 64
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_t      state, next_state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        size_ok;
  logic        align_ok;
  logic        req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] rmw_word;

  assign accept = bus.req_valid & bus.req_ready;

  // Request legality is judged on the live inputs so err_q is known at acceptance.
  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b0;
    if (bus.req_store) begin
      size_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010);
    end else begin
      size_ok = (bus.req_funct3 != 3'b011) && (bus.req_funct3 != 3'b110) &&
                (bus.req_funct3 != 3'b111);
    end
    case (bus.req_funct3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~bus.req_addr[0];
      2'b10:   align_ok = (bus.req_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    req_err = ~size_ok | ~align_ok | (bus.req_addr >= ADDR_LIMIT);
  end

  always_comb begin
    load_byte = 8'h00;
    case (addr_q[1:0])
      2'b00: load_byte = bus.read_data[7:0];
      2'b01: load_byte = bus.read_data[15:8];
      2'b10: load_byte = bus.read_data[23:16];
      2'b11: load_byte = bus.read_data[31:24];
    endcase
    load_half = addr_q[1] ? bus.read_data[31:16] : bus.read_data[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = bus.read_data;
    endcase
  end

  always_comb begin
    rmw_word = bus.read_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00: rmw_word[7:0]   = wdata_q[7:0];
        2'b01: rmw_word[15:8]  = wdata_q[7:0];
        2'b10: rmw_word[23:16] = wdata_q[7:0];
        2'b11: rmw_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      rmw_word[31:16] = wdata_q;
    end else begin
      rmw_word[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            next_state = RESP;
          end else if (!bus.req_store) begin
            next_state = LOAD;
          end else if (bus.req_funct3 == 3'b010) begin
            next_state = WRITE;
          end else begin
            next_state = RMW_RD;
          end
        end
      end
      LOAD:    next_state = RESP;
      RMW_RD:  next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 16'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata[15:0];
            rdata_q  <= 32'h0;
            err_q    <= req_err;
            if (bus.req_store && !req_err && bus.req_funct3 == 3'b010) begin
              merge_q <= bus.req_wdata;
            end
          end
        end
        LOAD:    rdata_q <= load_ext;
        RMW_RD:  merge_q <= rmw_word;
        default: ;
      endcase
    end
  end

  // The rst term keeps the write strobe off even before the async reset lands on state.
  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_write  = (state == WRITE) & ~rst;
  assign bus.rw_addr    = {addr_q[31:2], 2'b00};
  assign bus.write_data = merge_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed and random checks of lsu against a word-array reference model
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  lsu_if bus ();

  lsu #(.MEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  assign bus.read_data = mem[bus.rw_addr[7:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.rw_addr[7:2]] <= bus.write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic exp_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    return ((a % nbytes(f3)) != 0) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    int n, off;
    w   = ref_mem[a / 4];
    n   = nbytes(f3);
    off = int'(a % 4);
    if (n == 4) return w;
    v = (w >> (8 * off)) & ((32'd1 << (8 * n)) - 1);
    if (f3 < 3'd4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int n, off;
    n    = nbytes(f3);
    off  = int'(a % 4);
    mask = (n == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * n)) - 1) << (8 * off));
    ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | ((wd << (8 * off)) & mask);
  endtask

  // Called just after a falling edge with the LSU idle; returns at a falling edge, idle again.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int stall);
    logic        e_err;
    int          e_lat, lat, writes;
    logic [31:0] e_rd, hold_rd;
    logic        hold_err;
    e_err = exp_err(st, f3, a);
    e_lat = e_err ? 1 : (!st ? 2 : (f3 == 3'd2 ? 2 : 3));
    e_rd  = (!e_err && !st) ? exp_load(f3, a) : 32'h0;
    if (st && !e_err) ref_store(f3, a, wd);

    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.resp_ready = (stall == 0);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_store  = $urandom_range(0, 1);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 1;
    writes = 0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.mem_write) begin
        writes++;
        chk("rw_addr", bus.rw_addr, a & 32'hFFFF_FFFC);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, e_lat);
    chk("resp_rdata", bus.resp_rdata, e_rd);
    chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e_err});
    chk("write_count", writes, (st && !e_err) ? 1 : 0);
    hold_rd  = bus.resp_rdata;
    hold_err = bus.resp_err;
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      bus.req_store = 1'b1;
      bus.req_addr  = $urandom_range(0, 63) * 4;
      @(negedge clk);
      chk("stall_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("stall_rdata", bus.resp_rdata, hold_rd);
      chk("stall_err", {31'b0, bus.resp_err}, {31'b0, hold_err});
      chk("stall_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("stall_mem_write", {31'b0, bus.mem_write}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    chk("resp_done", {31'b0, bus.resp_valid}, 32'd0);
    chk("back_idle", {31'b0, bus.req_ready}, 32'd1);
  endtask

  task automatic chk_mem();
    for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;

    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    chk("lw_value", ref_mem[4], 32'hDEADBEEF);

    run_req(1'b1, 3'b010, 32'h20, 32'h8081F0F1, 0);
    run_req(1'b0, 3'b000, 32'h23, 32'h0, 0);
    run_req(1'b0, 3'b100, 32'h23, 32'h0, 0);
    run_req(1'b0, 3'b001, 32'h22, 32'h0, 0);
    run_req(1'b0, 3'b101, 32'h20, 32'h0, 0);
    chk("model_lb", exp_load(3'b000, 32'h23), 32'hFFFFFF80);
    chk("model_lhu", exp_load(3'b101, 32'h20), 32'h0000F0F1);

    run_req(1'b1, 3'b010, 32'h30, 32'h11223344, 0);
    run_req(1'b1, 3'b000, 32'h31, 32'h000000AB, 0);
    chk("sb_word", mem[12], 32'h1122AB44);
    run_req(1'b1, 3'b001, 32'h32, 32'h0000CDEF, 0);
    chk("sh_word", mem[12], 32'hCDEFAB44);

    run_req(1'b0, 3'b001, 32'h01, 32'h0, 0);
    run_req(1'b1, 3'b010, 32'h02, 32'h12345678, 0);
    run_req(1'b0, 3'b011, 32'h10, 32'h0, 0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, 0);
    chk_mem();

    run_req(1'b0, 3'b010, 32'h30, 32'h0, 5);

    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h31;
    bus.req_wdata  = 32'h00000077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("midrst_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("after_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("midrst_word", mem[12], 32'hCDEFAB44);

    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
              $urandom_range(0, 2));
    end
    chk_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the core's execute stage and the `dm` data memory. It accepts one load or store request at a time over a valid/ready handshake, drives the memory's `mem_write`/`rw_addr`/`write_data` inputs, and consumes its combinational `read_data`. It adds byte/halfword/word access with sign or zero extension on top of the word-only memory, using read-modify-write for sub-word stores. It flags misaligned, out-of-range and illegal-size requests without touching memory.

## Interface
- `MEM_WORDS`, 64, depth of the attached data memory in 32-bit words; byte addresses ≥ MEM_WORDS*4 are out of range.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: LSU can accept; high only in IDLE and while `rst` is low.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: core accepts the response.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: request was rejected with no memory access.
- `mem_write` out 1: to `dm` write enable.
- `rw_addr` out 32: to `dm` address, always word-aligned as {addr_q[31:2],2'b00}.
- `write_data` out 32: to `dm` write data.
- `read_data` in 32: from `dm`, combinational read of `rw_addr`.

## Operation
- **State machine:** IDLE, LOAD, RMW_RD, WRITE, RESP.
- **IDLE:** `req_ready`=1. On `req_valid & req_ready`, latch `req_store`, `req_funct3`, `req_addr` and `req_wdata` into `*_q`, then check the request. A request is an error if any of the following holds:
  - funct3 is illegal for its direction (loads 011/110/111; stores anything other than 000/001/010);
  - it is misaligned (halfword with addr[0]=1; word with addr[1:0]≠0);
  - addr ≥ MEM_WORDS*4.
- **IDLE transitions:**
  - error → RESP with err_q=1;
  - load → LOAD;
  - SW → WRITE, with merge_q=wdata;
  - SB/SH → RMW_RD.
- **LOAD:** capture `read_data`, select the byte or halfword lane by addr_q[1:0], and sign-extend (LB/LH) or zero-extend (LBU/LHU) into rdata_q. LW passes the full word. Then → RESP.
- **RMW_RD:** capture `read_data` into merge_q with the addressed lane replaced by wdata_q[7:0] (SB, lane addr_q[1:0]) or wdata_q[15:0] (SH, lane addr_q[1]). Then → WRITE.
- **WRITE:** `mem_write`=1 and `write_data`=merge_q for exactly this one cycle. Then → RESP.
- **RESP:** `resp_valid`=1, with `resp_rdata`=rdata_q (0 for stores and errors) and `resp_err`=err_q. All three are held stable until `resp_ready`. On `resp_valid & resp_ready` → IDLE.
- **Outside WRITE:** `mem_write`=0. `write_data`=merge_q (don't-care to `dm`).
- **Memory isolation:** errored requests never assert `mem_write` and never reach LOAD, RMW_RD or WRITE.

## Timing
- **Reset** (asynchronous, immediate) drives: state=IDLE, `mem_write`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `req_ready`=0 while `rst`=1 and 1 from the first cycle after release, and all `*_q`, merge_q and rdata_q=0.
- **Latency**, counted from the acceptance edge (edge 0) to the first cycle with `resp_valid`=1:
  - load: 2 cycles (LOAD, RESP);
  - SW: 2 cycles (WRITE, RESP);
  - SB/SH: 3 cycles (RMW_RD, WRITE, RESP);
  - error: 1 cycle.
- **Memory write:** the `dm` array updates on the edge that ends WRITE. A load accepted in the cycle after RESP sees the new value.
- **Back-to-back throughput:** with `resp_ready` held high, requests are accepted every 3 cycles for loads/SW and every 4 for SB/SH. There is no same-cycle RESP→accept; `req_ready` is low in RESP.
- **Stalled response:** if `resp_ready`=0 the LSU stays in RESP indefinitely, and `req_valid` is ignored.
- **Reset mid-operation:** the in-flight request is dropped with no response. Reset during RMW_RD leaves memory unchanged. Reset during WRITE deasserts `mem_write` before the edge, so no write occurs if reset is asserted before that edge.
- **Request inputs** are sampled only at the acceptance edge. Later changes to them have no effect.

## Test plan
- **Reset, then SW and LW:** reset; SW addr 0x10 data 0xDEADBEEF; LW 0x10 → `mem_write` high for 1 cycle with rw_addr=0x10; load `resp_rdata`=0xDEADBEEF, `resp_err`=0; load latency 2 cycles.
- **Sub-word loads:** word 0x8081F0F1 at 0x20:
  - LB 0x23 → 0xFFFFFF80;
  - LBU 0x23 → 0x00000080;
  - LH 0x22 → 0xFFFF8081;
  - LHU 0x20 → 0x0000F0F1.
- **Read-modify-write stores:** preload 0x11223344 at 0x30; SB 0x31 data 0xAB → word 0x1122AB44; SH 0x32 data 0xCDEF → word 0xCDEFAB44; each takes 3 cycles to `resp_valid`.
- **Errors:** LH 0x01, SW 0x02, load funct3=011, and LW 0x100 (MEM_WORDS=64) → `resp_err`=1 after 1 cycle, `resp_rdata`=0, `mem_write` never asserted, memory contents unchanged.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles with `req_valid`=1 → `resp_valid`, `resp_rdata` and `resp_err` stable and `req_ready`=0 throughout; no second access begins; the response completes on the first `resp_ready`=1.
- **Reset mid-SB:** assert `rst` during RMW_RD of SB 0x31 → no write; the word is unchanged; `resp_valid`=0 and `req_ready`=1 in the first cycle after release.
